// File: rtl/scalar_mult_ctrl_if.sv
// rtl/scalar_mult_ctrl_if.sv - request/result and point_add operand bundle for scalar_mult_ctrl
interface scalar_mult_ctrl_if #(
    parameter int WIDTH = 256,
    parameter int NBITS = 256
);
    logic                 start;
    logic [NBITS-1:0]     k;
    logic [2*WIDTH-1:0]   P;
    logic [2*WIDTH-1:0]   R;
    logic                 Done;
    logic                 busy;
    logic [2*WIDTH-1:0]   pa_P;
    logic [2*WIDTH-1:0]   pa_Q;
    logic                 pa_reset;
    logic [2*WIDTH-1:0]   pa_R;
    logic                 pa_done;

    // Requester plus the point_add instance it pairs with
    modport master (
        output start, k, P, pa_R, pa_done,
        input  R, Done, busy, pa_P, pa_Q, pa_reset
    );

    // The sequencer itself
    modport slave (
        input  start, k, P, pa_R, pa_done,
        output R, Done, busy, pa_P, pa_Q, pa_reset
    );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// rtl/scalar_mult_ctrl.sv - double-and-add sequencer driving one external point_add
module scalar_mult_ctrl #(
    parameter int WIDTH = 256,
    parameter int NBITS = 256
) (
    input  logic               clk,
    input  logic               Reset,
    scalar_mult_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        ADD_L  = 3'd2,
        ADD_W  = 3'd3,
        DBL_L  = 3'd4,
        DBL_W  = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   base;
    logic [NBITS-1:0]     ks;

    // Cleared on every launch; set after the first wait cycle so a Done left
    // over from the previous adder operation is never taken as the new result.
    logic                 armed;
    logic                 accept;
    logic                 ks_rest_zero;

    assign accept       = armed && bus.pa_done;
    assign ks_rest_zero = (ks[NBITS-1:1] == '0);

    // State register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and the point_add restart pulse
    always_comb begin
        state_nxt    = state;
        bus.pa_reset = Reset || (state == ADD_L) || (state == DBL_L);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.k == '0) ? FINISH : SEL;
                end
            end
            SEL: begin
                state_nxt = ks[0] ? ADD_L : DBL_L;
            end
            ADD_L: begin
                state_nxt = ADD_W;
            end
            ADD_W: begin
                if (accept) begin
                    // Nothing above this bit is set: stop without a wasted doubling
                    state_nxt = ks_rest_zero ? FINISH : DBL_L;
                end
            end
            DBL_L: begin
                state_nxt = DBL_W;
            end
            DBL_W: begin
                if (accept) begin
                    state_nxt = SEL;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, adder operand registers, result and status
    always_ff @(posedge clk) begin
        if (Reset) begin
            acc      <= '0;
            base     <= '0;
            ks       <= '0;
            armed    <= 1'b0;
            bus.pa_P <= '0;
            bus.pa_Q <= '0;
            bus.R    <= '0;
            bus.Done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        base     <= bus.P;
                        ks       <= bus.k;
                        bus.Done <= 1'b0;
                        bus.busy <= 1'b1;
                    end
                end
                ADD_L: begin
                    bus.pa_P <= acc;
                    bus.pa_Q <= base;
                    armed    <= 1'b0;
                end
                ADD_W: begin
                    armed <= 1'b1;
                    if (accept) begin
                        acc <= bus.pa_R;
                    end
                end
                DBL_L: begin
                    bus.pa_P <= base;
                    bus.pa_Q <= base;
                    armed    <= 1'b0;
                end
                DBL_W: begin
                    armed <= 1'b1;
                    if (accept) begin
                        base <= bus.pa_R;
                        ks   <= {1'b0, ks[NBITS-1:1]};
                    end
                end
                FINISH: begin
                    bus.R    <= acc;
                    bus.Done <= 1'b1;
                    bus.busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb/tb_scalar_mult_ctrl.sv - randomized self-checking bench for scalar_mult_ctrl
module tb_scalar_mult_ctrl;

    localparam int W  = 16;
    localparam int N  = 12;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    scalar_mult_ctrl_if #(.WIDTH(W), .NBITS(N)) bus();

    scalar_mult_ctrl #(.WIDTH(W), .NBITS(N)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 2;
    int acnt     = 0;

    localparam logic [PW-1:0] G = {16'h1798, 16'hD4B8};

    // Stand-in adder: component-wise sum mod 2^W, (0,0) is the identity.
    // Done is left stale across the restart pulse to exercise the guard.
    always @(posedge clk) begin
        if (bus.pa_reset) begin
            acnt <= 0;
            if (Reset) begin
                bus.pa_done <= 1'b0;
                bus.pa_R    <= '0;
            end
        end else if (acnt < lat) begin
            acnt        <= acnt + 1;
            bus.pa_done <= (acnt + 1 == lat);
            if (acnt + 1 == lat) begin
                bus.pa_R <= {W'(bus.pa_P[PW-1:W] + bus.pa_Q[PW-1:W]),
                             W'(bus.pa_P[W-1:0]  + bus.pa_Q[W-1:0])};
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mult(input logic [N-1:0] kk, input logic [PW-1:0] pp);
        logic [63:0] rx;
        logic [63:0] ry;
        rx = 64'(kk) * 64'(pp[PW-1:W]);
        ry = 64'(kk) * 64'(pp[W-1:0]);
        return {rx[W-1:0], ry[W-1:0]};
    endfunction

    function automatic int msb_index(input logic [N-1:0] kk);
        int m;
        m = -1;
        for (int i = 0; i < N; i++) begin
            if (kk[i]) m = i;
        end
        return m;
    endfunction

    task automatic run_op(input logic [N-1:0] kk, input logic [PW-1:0] pp, input int l, input bit inject);
        int n;
        int pulses;
        int msb;
        int pop;
        int exp_n;
        bit busy_ok;
        bit r_ok;
        logic [PW-1:0] r_prev;
        lat    = l;
        r_prev = bus.R;
        bus.start = 1'b1;
        bus.k     = kk;
        bus.P     = pp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.k     = N'($urandom);
        bus.P     = PW'($urandom);
        check_eq("done_clr", bus.Done, 0);
        check_eq("busy_set", bus.busy, 1);
        n = 0;
        pulses = 0;
        busy_ok = 1'b1;
        r_ok = 1'b1;
        while (!bus.Done && n < 2000) begin
            if (bus.pa_reset) pulses++;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.R !== r_prev) r_ok = 1'b0;
            if (inject && n == 3) begin
                bus.start = 1'b1;
                bus.k     = N'(5);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        msb = msb_index(kk);
        pop = $countones(kk);
        exp_n = (kk == '0) ? 1 : (msb + 1) + (pop + msb) * (l + 2) + 1;
        check_eq("latency", 64'(n), 64'(exp_n));
        check_eq("result", bus.R, ref_mult(kk, pp));
        check_eq("pa_pulses", 64'(pulses), (kk == '0) ? 64'd0 : 64'(pop + msb));
        check_eq("busy_run", busy_ok, 1);
        check_eq("r_hold", r_ok, 1);
        check_eq("busy_clr", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("done_hold", bus.Done, 1);
    endtask

    task automatic reset_in_dbl_w();
        int n;
        lat = 3;
        bus.start = 1'b1;
        bus.k     = N'(12);
        bus.P     = G;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.pa_reset && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("dbl_launch_seen", bus.pa_reset, 1);
        @(posedge clk); #1;
        check_eq("dbl_w_operands", bus.pa_P, G);
        Reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_done", bus.Done, 0);
        check_eq("rst_mid_busy", bus.busy, 0);
        check_eq("rst_mid_pa_reset", bus.pa_reset, 1);
        Reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_idle_pa_reset", bus.pa_reset, 0);
        check_eq("rst_idle_busy", bus.busy, 0);
        run_op(N'(1), G, 3, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        bus.start = 1'b0;
        bus.k     = '0;
        bus.P     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_R", bus.R, 0);
        check_eq("rst_done", bus.Done, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_pa_P", bus.pa_P, 0);
        check_eq("rst_pa_Q", bus.pa_Q, 0);
        check_eq("rst_pa_reset", bus.pa_reset, 1);
        Reset = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_pa_reset", bus.pa_reset, 0);

        run_op(N'(0), G, 2, 1'b0);
        run_op(N'(1), G, 2, 1'b0);
        run_op(N'(2), G, 1, 1'b0);
        run_op(N'(3), G, 3, 1'b0);
        run_op(N'(12'hFFF), G, 2, 1'b0);
        run_op(N'(12'h09A), G, 2, 1'b1);
        run_op(N'(12'h800), PW'($urandom), 1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(N'($urandom), PW'($urandom), int'($urandom_range(1, 4)), i[0]);
        end

        reset_in_dbl_w();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
